// File: rtl/huff_pkg.sv
// huff_pkg: shared state enum, default sizes and clog2 helper
// for the canonical Huffman encoder slice.
package huff_pkg;

    localparam int SYM_W_D   = 8;
    localparam int MAX_LEN_D = 15;
    localparam int OUT_W_D   = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT,
        ST_BASE,
        ST_ASSIGN,
        ST_ENCODE,
        ST_FLUSH
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/huff_bit_packer.sv
// huff_bit_packer: MSB-first variable-length bit accumulator
// with word emit, final flush and valid/ready output register.
module huff_bit_packer
    import huff_pkg::*;
#(
    parameter int  MAX_LEN = MAX_LEN_D,
    parameter int  OUT_W   = OUT_W_D,
    localparam int LEN_W   = clog2(MAX_LEN + 1),
    localparam int CNT_W   = clog2(OUT_W + 1),
    localparam int AW      = OUT_W + MAX_LEN - 1,
    localparam int FW      = clog2(AW + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               app_en,
    input  logic [MAX_LEN-1:0] app_code,
    input  logic [LEN_W-1:0]   app_len,
    input  logic               pkt_last,
    input  logic               flush,
    output logic [FW-1:0]      fill,
    output logic               done,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [OUT_W-1:0]   m_data,
    output logic [CNT_W-1:0]   m_bits,
    output logic               m_last
);

    logic [AW-1:0] acc;
    logic [AW-1:0] acc_sh;
    logic [AW-1:0] app_al;
    logic [FW-1:0] fill_sh;
    logic          out_free;
    logic          full;
    logic          emit_full;
    logic          emit_fin;

    assign out_free  = !m_valid || m_ready;
    assign full      = fill >= FW'(OUT_W);
    assign emit_full = full && out_free;
    assign emit_fin  = flush && !full && out_free
                       && !(m_valid && m_last);
    assign done      = m_valid && m_ready && m_last;

    // New bits land just below whatever survives this cycle's emit
    always_comb begin
        acc_sh  = emit_full ? acc << OUT_W : acc;
        fill_sh = emit_full ? fill - FW'(OUT_W) : fill;
        app_al  = (AW'(app_code) << (AW - int'(app_len)))
                  >> fill_sh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            fill    <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_bits  <= '0;
            m_last  <= 1'b0;
        end else begin
            if (emit_full) begin
                m_data <= acc[AW-1 -: OUT_W];
                m_bits <= CNT_W'(OUT_W);
                m_last <= pkt_last && !app_en
                          && (fill == FW'(OUT_W));
            end else if (emit_fin) begin
                m_data <= acc[AW-1 -: OUT_W];
                m_bits <= CNT_W'(fill);
                m_last <= 1'b1;
            end
            if (emit_full || emit_fin) begin
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (emit_fin) begin
                acc  <= '0;
                fill <= '0;
            end else if (app_en) begin
                acc  <= acc_sh | app_al;
                fill <= fill_sh + FW'(app_len);
            end else begin
                acc  <= acc_sh;
                fill <= fill_sh;
            end
        end
    end

endmodule

// File: rtl/huff_canon_encoder.sv
// huff_canon_encoder: builds canonical codes from a length table and
// packs a symbol stream; HUFF_KRAFT_CHK_EN adds the oversubscription check.
module huff_canon_encoder
    import huff_pkg::*;
#(
    parameter int  SYM_W   = SYM_W_D,
    parameter int  MAX_LEN = MAX_LEN_D,
    parameter int  OUT_W   = OUT_W_D,
    localparam int NSYM    = 2 ** SYM_W,
    localparam int LEN_W   = clog2(MAX_LEN + 1),
    localparam int CNT_W   = clog2(OUT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tbl_wr_en,
    input  logic [SYM_W-1:0] tbl_wr_sym,
    input  logic [LEN_W-1:0] tbl_wr_len,
    input  logic             build_start,
    input  logic             reload,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [SYM_W-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic [CNT_W-1:0] m_bits,
    output logic             m_last,
    output logic             busy,
    output logic             tbl_ok,
`ifdef HUFF_KRAFT_CHK_EN
    output logic             err_kraft,
`endif
    output logic             err_zero_len
);

    localparam int FW  = clog2(OUT_W + MAX_LEN);
    localparam int BCW = SYM_W + 1;
    // Headroom so an oversubscribed sum cannot wrap
    localparam int NCW = MAX_LEN + SYM_W + 2;

    state_t state, state_n;

    logic [LEN_W-1:0]   len_mem   [NSYM];
    logic [MAX_LEN-1:0] code_mem  [NSYM];
    logic [BCW-1:0]     bl_count  [MAX_LEN+1];
    logic [NCW-1:0]     next_code [MAX_LEN+1];

    logic [NCW-1:0]   code, code_n;
    logic [BCW-1:0]   prev_cnt;
    logic [SYM_W-1:0] idx;
    logic [LEN_W-1:0] lidx;
    logic [LEN_W-1:0] cur_len;
    logic [LEN_W-1:0] in_len;
    logic [FW-1:0]    fill;
    logic             last_seen;
    logic             hs;
    logic             app_en;
    logic             done;
    logic             reload_ok;
    logic             kraft_bad;

    assign cur_len   = len_mem[idx];
    assign in_len    = len_mem[s_data];
    assign s_ready   = (state == ST_ENCODE) && !last_seen
                       && (fill < FW'(OUT_W));
    assign hs        = s_valid && s_ready;
    assign app_en    = hs && (in_len != '0);
    assign busy      = state != ST_IDLE;
    assign reload_ok = reload && !hs && (fill == '0)
                       && !m_valid && !last_seen;

    assign prev_cnt = (lidx == LEN_W'(1)) ? '0
                      : bl_count[lidx - LEN_W'(1)];
    assign code_n   = (code + NCW'(prev_cnt)) << 1;

`ifdef HUFF_KRAFT_CHK_EN
    assign kraft_bad = (code_n + NCW'(bl_count[lidx]))
                       > (NCW'(1) << lidx);
`else
    assign kraft_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE:
                if (build_start) state_n = ST_CNT;
            ST_CNT:
                if (idx == '1) state_n = ST_BASE;
            ST_BASE:
                if (kraft_bad) state_n = ST_IDLE;
                else if (lidx == LEN_W'(MAX_LEN)) state_n = ST_ASSIGN;
            ST_ASSIGN:
                if (idx == '1) state_n = ST_ENCODE;
            ST_ENCODE:
                if (reload_ok) state_n = ST_IDLE;
                else if (last_seen && !done
                         && fill < FW'(OUT_W)) state_n = ST_FLUSH;
            ST_FLUSH:
                if (done) state_n = ST_ENCODE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            lidx         <= '0;
            code         <= '0;
            last_seen    <= 1'b0;
            tbl_ok       <= 1'b0;
            err_zero_len <= 1'b0;
            for (int i = 0; i < NSYM; i++) begin
                len_mem[i]  <= '0;
                code_mem[i] <= '0;
            end
            for (int l = 0; l <= MAX_LEN; l++) begin
                bl_count[l]  <= '0;
                next_code[l] <= '0;
            end
        end else begin
            err_zero_len <= hs && (in_len == '0);
            if (done) last_seen <= 1'b0;
            else if (hs && s_last) last_seen <= 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (tbl_wr_en) begin
                        len_mem[tbl_wr_sym] <= tbl_wr_len;
                        tbl_ok <= 1'b0;
                    end
                    if (build_start) begin
                        for (int l = 0; l <= MAX_LEN; l++)
                            bl_count[l] <= '0;
                        idx    <= '0;
                        lidx   <= LEN_W'(1);
                        code   <= '0;
                        tbl_ok <= 1'b0;
                    end
                end
                ST_CNT: begin
                    if (cur_len != '0)
                        bl_count[cur_len] <= bl_count[cur_len] + 1'b1;
                    idx <= idx + 1'b1;
                end
                ST_BASE: begin
                    code            <= code_n;
                    next_code[lidx] <= code_n;
                    lidx            <= lidx + 1'b1;
                end
                ST_ASSIGN: begin
                    if (cur_len != '0) begin
                        code_mem[idx] <= MAX_LEN'(next_code[cur_len]);
                        next_code[cur_len] <= next_code[cur_len] + 1'b1;
                    end
                    idx <= idx + 1'b1;
                    if (idx == '1) tbl_ok <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef HUFF_KRAFT_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_kraft <= 1'b0;
        else if (state == ST_IDLE && build_start) err_kraft <= 1'b0;
        else if (state == ST_BASE && kraft_bad) err_kraft <= 1'b1;
    end
`endif

    huff_bit_packer #(
        .MAX_LEN (MAX_LEN),
        .OUT_W   (OUT_W)
    ) u_pack (
        .clk      (clk),
        .rst_n    (rst_n),
        .app_en   (app_en),
        .app_code (code_mem[s_data]),
        .app_len  (in_len),
        .pkt_last (last_seen || (hs && s_last)),
        .flush    (state == ST_FLUSH),
        .fill     (fill),
        .done     (done),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_bits   (m_bits),
        .m_last   (m_last)
    );

endmodule

// File: tb/tb_huff_canon_encoder.sv
// tb_huff_canon_encoder: directed stimulus against a canonical-code
// and bit-queue model of the encoder.
module tb_huff_canon_encoder;

    logic        clk;
    logic        rst_n;
    logic        tbl_wr_en;
    logic [7:0]  tbl_wr_sym;
    logic [3:0]  tbl_wr_len;
    logic        build_start;
    logic        reload;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [5:0]  m_bits;
    logic        m_last;
    logic        busy;
    logic        tbl_ok;
    logic        err_zero_len;
`ifdef HUFF_KRAFT_CHK_EN
    logic        err_kraft;
`endif

    huff_canon_encoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tbl_wr_en    (tbl_wr_en),
        .tbl_wr_sym   (tbl_wr_sym),
        .tbl_wr_len   (tbl_wr_len),
        .build_start  (build_start),
        .reload       (reload),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_bits       (m_bits),
        .m_last       (m_last),
        .busy         (busy),
        .tbl_ok       (tbl_ok),
`ifdef HUFF_KRAFT_CHK_EN
        .err_kraft    (err_kraft),
`endif
        .err_zero_len (err_zero_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    int mlen [256];
    int mcode [256];

    bit          exp_q [$];
    int          marks [$];
    int          in_cnt, out_cnt, zl_cnt;
    bit          zl_exp;
    bit          hold_v;
    logic [31:0] hold_d;
    logic [5:0]  hold_b;
    logic        hold_l;

    logic [31:0] cap_d [$];
    int          cap_b [$];
    bit          cap_l [$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Canonical codes by walking lengths then symbols in order
    function automatic void build_model();
        int c = 0;
        for (int l = 1; l <= 15; l++) begin
            for (int s = 0; s < 256; s++)
                if (mlen[s] == l) begin
                    mcode[s] = c;
                    c++;
                end
            c = c << 1;
        end
    endfunction

    task automatic check_word();
        int rem, eb;
        bit el, avail;
        logic [31:0] ed;
        rem = marks.size() > 0 ? marks[0] - out_cnt : 1 << 30;
        eb = rem < 32 ? rem : 32;
        el = marks.size() > 0 && rem <= 32;
        ed = '0;
        avail = 1;
        for (int i = 0; i < eb; i++) begin
            if (exp_q.size() > 0) ed[31-i] = exp_q.pop_front();
            else avail = 0;
        end
        chk("word_avail", avail, 1);
        chk("word_data", m_data, ed);
        chk("word_bits", m_bits, eb);
        chk("word_last", m_last, el);
        out_cnt += eb;
        if (el) void'(marks.pop_front());
        cap_d.push_back(m_data);
        cap_b.push_back(int'(m_bits));
        cap_l.push_back(m_last);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            marks.delete();
            in_cnt = 0;
            out_cnt = 0;
            zl_exp = 0;
            hold_v = 0;
        end else begin
            chk("err_zero_len", err_zero_len, zl_exp);
            if (err_zero_len) zl_cnt++;
            if (hold_v) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, hold_d);
                chk("hold_bits", m_bits, hold_b);
                chk("hold_last", m_last, hold_l);
            end
            if (m_valid && m_ready) check_word();
            zl_exp = 0;
            if (s_valid && s_ready) begin
                int ln, cd;
                ln = mlen[s_data];
                cd = mcode[s_data];
                if (ln == 0) zl_exp = 1;
                for (int i = ln - 1; i >= 0; i--)
                    exp_q.push_back(cd[i]);
                in_cnt += ln;
                if (s_last) marks.push_back(in_cnt);
            end
            hold_v = m_valid && !m_ready;
            hold_d = m_data;
            hold_b = m_bits;
            hold_l = m_last;
        end
    end

    task automatic wr(input int sym, input int ln);
        tbl_wr_en = 1;
        tbl_wr_sym = sym[7:0];
        tbl_wr_len = ln[3:0];
        @(posedge clk);
        #1 tbl_wr_en = 0;
        mlen[sym] = ln;
    endtask

    task automatic send(input int sym, input bit last);
        int n = 0;
        s_valid = 1;
        s_data = sym[7:0];
        s_last = last;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 300) begin
                chk("send_s_ready", s_ready, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 0;
        s_last = 0;
    endtask

    task automatic wait_last();
        bit found = 0;
        int n = 0;
        while (!found && n < 400) begin
            @(negedge clk);
            n++;
            foreach (cap_l[i]) if (cap_l[i]) found = 1;
        end
        chk("wait_last", found, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic cap_clear();
        cap_d.delete();
        cap_b.delete();
        cap_l.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_m_bits"}, m_bits, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_tbl_ok"}, tbl_ok, 0);
        chk({tag, "_err_zero_len"}, err_zero_len, 0);
    endtask

    initial begin
        int n;
        rst_n = 0;
        tbl_wr_en = 0;
        tbl_wr_sym = 0;
        tbl_wr_len = 0;
        build_start = 0;
        reload = 0;
        s_valid = 0;
        s_data = 0;
        s_last = 0;
        m_ready = 0;
        zl_cnt = 0;
        foreach (mlen[i]) begin
            mlen[i] = 0;
            mcode[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk);
        #1;

        wr(0, 1);
        wr(1, 2);
        wr(2, 3);
        wr(3, 3);
        build_model();
        chk("model_code0", mcode[0], 0);
        chk("model_code1", mcode[1], 2);
        chk("model_code2", mcode[2], 6);
        chk("model_code3", mcode[3], 7);

        build_start = 1;
        @(posedge clk);
        #1 build_start = 0;
        chk("busy_build", busy, 1);
        n = 0;
        while (!tbl_ok && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("build_latency", n, 527);
        chk("tbl_ok_built", tbl_ok, 1);

        m_ready = 1;
        cap_clear();
        send(0, 0);
        send(1, 0);
        send(2, 0);
        send(3, 1);
        wait_last();
        chk("p1_words", cap_d.size(), 1);
        if (cap_d.size() > 0) begin
            chk("p1_data", cap_d[0], 32'h5B80_0000);
            chk("p1_bits", cap_b[0], 9);
            chk("p1_last", cap_l[0], 1);
        end

        cap_clear();
        for (int k = 0; k < 11; k++) send(3, k == 10);
        wait_last();
        chk("p2_words", cap_d.size(), 2);
        if (cap_d.size() > 1) begin
            chk("p2_d0", cap_d[0], 32'hFFFF_FFFF);
            chk("p2_b0", cap_b[0], 32);
            chk("p2_l0", cap_l[0], 0);
            chk("p2_d1", cap_d[1], 32'h8000_0000);
            chk("p2_b1", cap_b[1], 1);
            chk("p2_l1", cap_l[1], 1);
        end

        cap_clear();
        m_ready = 0;
        fork
            begin
                for (int k = 0; k < 24; k++) send(2, k == 23);
            end
            begin
                repeat (80) @(negedge clk);
                chk("stall_s_ready", s_ready, 0);
                chk("stall_m_valid", m_valid, 1);
                @(posedge clk);
                #1 m_ready = 1;
            end
        join
        wait_last();
        chk("p3_words", cap_d.size(), 3);
        if (cap_d.size() > 2) begin
            chk("p3_d0", cap_d[0], 32'hDB6D_B6DB);
            chk("p3_d2", cap_d[2], 32'hB600_0000);
            chk("p3_b2", cap_b[2], 8);
            chk("p3_l2", cap_l[2], 1);
        end

        cap_clear();
        zl_cnt = 0;
        send(0, 0);
        send(9, 0);
        send(1, 1);
        wait_last();
        chk("zl_pulses", zl_cnt, 1);
        chk("p4_words", cap_d.size(), 1);
        if (cap_d.size() > 0) begin
            chk("p4_data", cap_d[0], 32'h4000_0000);
            chk("p4_bits", cap_b[0], 3);
        end

        reload = 1;
        @(posedge clk);
        #1 reload = 0;
        @(negedge clk);
        chk("reload_busy", busy, 0);
        chk("reload_tbl_ok", tbl_ok, 1);
        @(posedge clk);
        #1 build_start = 1;
        @(posedge clk);
        #1 build_start = 0;
        repeat (400) @(posedge clk);
        #1;
        chk("assign_busy", busy, 1);
        chk("assign_tbl_ok", tbl_ok, 0);
        #2 rst_n = 0;
        @(negedge clk);
        check_reset_vals("midrst");
        @(posedge clk);
        #1 rst_n = 1;
        foreach (mlen[i]) mlen[i] = 0;

`ifdef HUFF_KRAFT_CHK_EN
        wr(0, 1);
        wr(1, 1);
        wr(2, 1);
        build_start = 1;
        @(posedge clk);
        #1 build_start = 0;
        n = 0;
        while (busy && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("kraft_err", err_kraft, 1);
        chk("kraft_idle", busy, 0);
        chk("kraft_tbl_ok", tbl_ok, 0);
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/huff_canon_encoder.md
Name: huff_canon_encoder

Overview:
- Parametrised canonical-Huffman stream encoder; successor to the fixed 8-bit single-shot Huffman encoder.
- Software or an upstream block loads per-symbol code lengths. The block derives canonical codes in hardware.
- It then encodes a valid/ready symbol stream into MSB-first packed OUT_W-bit words.
- Sits between the symbol source (tokeniser/stats block) and the compressed-stream writer.

Parameters:
- SYM_W, 8: symbol width. NSYM = 2**SYM_W (localparam).
- MAX_LEN, 15: maximum code length. LEN_W = $clog2(MAX_LEN+1) (localparam).
- OUT_W, 32: packed output word width. Must satisfy OUT_W >= MAX_LEN. CNT_W = $clog2(OUT_W+1) (localparam).

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- tbl_wr_en, in, 1: length-table write strobe.
- tbl_wr_sym, in, SYM_W: symbol being written.
- tbl_wr_len, in, LEN_W: code length (0 = symbol unused).
- build_start, in, 1: pulse; start canonical code generation.
- reload, in, 1: pulse; return to IDLE for a table reload.
- s_valid, in, 1: input symbol valid.
- s_ready, out, 1: input symbol ready.
- s_data, in, SYM_W: input symbol.
- s_last, in, 1: last symbol of packet.
- m_valid, out, 1: output word valid.
- m_ready, in, 1: output word ready.
- m_data, out, OUT_W: packed bits, MSB = first bit.
- m_bits, out, CNT_W: valid bits in m_data (OUT_W, or fewer on the final word).
- m_last, out, 1: final word of packet.
- busy, out, 1: high when not in IDLE.
- tbl_ok, out, 1: code table built and valid.
- err_zero_len, out, 1: one-cycle pulse; a symbol of length 0 was presented.

Behaviour:
- Reset values: s_ready=0, m_valid=0, m_data=0, m_bits=0, m_last=0, busy=0, tbl_ok=0, err_zero_len=0. State = IDLE, accumulator fill = 0. len/code memories are cleared to 0.
- States: IDLE, CNT, BASE, ASSIGN, ENCODE, FLUSH.
- IDLE:
  - tbl_wr_en writes len_mem[tbl_wr_sym] and clears tbl_ok.
  - build_start moves to CNT; bl_count[] is cleared.
  - Writes are ignored in every other state. build_start is ignored outside IDLE.
- CNT:
  - Scans one symbol per cycle, NSYM cycles: bl_count[len]++ when len != 0.
- BASE:
  - One length per cycle, len = 1..MAX_LEN.
  - code = (code + bl_count[len-1]) << 1, with bl_count[0] forced to 0.
  - next_code[len] = code.
- ASSIGN:
  - One symbol per cycle, NSYM cycles.
  - If len != 0: code_mem[sym] = next_code[len], then next_code[len]++.
  - On the final symbol: tbl_ok=1, go to ENCODE.
  - Total build latency = 2*NSYM + MAX_LEN cycles from build_start.
- ENCODE:
  - s_ready = (fill < OUT_W) && !last_seen. The accumulator width is OUT_W+MAX_LEN-1, so it never overflows.
  - On handshake: append code_mem[s_data] (len bits, MSB first) below the existing bits; fill += len.
  - Zero-length symbol: it is dropped, fill is unchanged, err_zero_len pulses.
  - s_last handshake sets last_seen and moves to FLUSH once the accumulator holds < OUT_W bits.
- Word emit (ENCODE and FLUSH):
  - Condition: fill >= OUT_W and the output register is free (!m_valid || m_ready).
  - Action: top OUT_W bits go to m_data, m_bits=OUT_W, fill -= OUT_W.
  - m_valid rises the cycle after fill reaches OUT_W.
  - Emit and append in the same cycle are allowed; the new bits land after the shift.
- FLUSH:
  - If fill > 0: emit one word, zero-padded in the LSBs, with m_bits=fill and m_last=1.
  - If fill == 0 but a full word was last emitted: that word carries m_last=1 instead.
  - When the last word is accepted: clear last_seen, return to ENCODE. The table is retained.
- m_data/m_bits/m_last hold stable while m_valid && !m_ready.
- reload: honoured only in ENCODE with fill==0, !m_valid, !last_seen; goes to IDLE and keeps tbl_ok. Otherwise it is ignored.
- Reset mid-build or mid-packet aborts everything. Outputs return to reset values, tbl_ok=0, and the length table must be reloaded.

Optional Feature:
- Macro: HUFF_KRAFT_CHK_EN.
- With the macro defined:
  - In BASE, if next_code[len] + bl_count[len] > 2**len, the table is oversubscribed. The block raises a sticky err_kraft output (1 bit, reset 0, cleared by the next build_start), aborts to IDLE, and leaves tbl_ok=0.
- Without the macro: there is no err_kraft port and no check; an oversubscribed table yields undefined (non-prefix) codes.

Decomposition:
- Package huff_pkg holds:
  - the state enum;
  - a helper function clog2;
  - the default localparams for SYM_W/MAX_LEN/OUT_W.
- Sub-module huff_bit_packer: variable-length append accumulator, emit logic and flush, with the valid/ready output register. The top level keeps the FSM and the tables.

Test Plan:
- Load lens sym0=1, sym1=2, sym2=3, sym3=3, others 0; build_start → tbl_ok after 2*256+15 cycles; codes 0, 10, 110, 111.
- Same table, stream 0,1,2,3 (s_last on 3), m_ready=1 → one word m_data=0x5B80_0000, m_bits=9, m_last=1.
- Symbol 3 ×11, last on the 11th (33 bits) → word 0xFFFF_FFFF (m_bits=32, m_last=0), then 0x8000_0000 (m_bits=1, m_last=1).
- m_ready=0 while streaming sym2 → s_ready drops once fill ≥ 32; m_data held stable; no bits lost after m_ready=1.
- Symbol 9 (len 0) presented → err_zero_len pulses once; output bits unchanged.
- HUFF_KRAFT_CHK_EN: lens sym0..2 = 1 → err_kraft=1, state IDLE, tbl_ok=0. Separately, rst_n low during ASSIGN → all outputs at reset values next cycle.
